// File: rtl/actuator_guard_if.sv
// actuator_guard_if: request/interlock inputs and actuator drive outputs of the actuator guard.
interface actuator_guard_if;
    logic ena;
    logic req_fill;
    logic req_release;
    logic req_forward;
    logic req_reverse;
    logic door_closed;
    logic estop;
    logic clear_fault;
    logic out_fill;
    logic out_release;
    logic out_forward;
    logic out_reverse;
    logic busy;
    logic [2:0] fault;
    modport master (
        output ena, req_fill, req_release, req_forward, req_reverse, door_closed, estop, clear_fault,
        input  out_fill, out_release, out_forward, out_reverse, busy, fault
    );
    modport slave (
        input  ena, req_fill, req_release, req_forward, req_reverse, door_closed, estop, clear_fault,
        output out_fill, out_release, out_forward, out_reverse, busy, fault
    );
endinterface

// File: rtl/actuator_guard.sv
// actuator_guard: interlocks motor direction and fill/release valves with dead time, gaps and sticky faults.
module actuator_guard #(
    parameter int DEADTIME  = 8,
    parameter int VALVE_GAP = 2
) (
    input logic clk,
    input logic rst,
    actuator_guard_if.slave bus
);
    typedef enum logic [1:0] {M_IDLE, M_FWD, M_REV, M_BRAKE} m_state_t;
    typedef enum logic [1:0] {V_CLOSED, V_FILL, V_RELEASE, V_GAP} v_state_t;
    localparam logic [7:0] DT_LOAD  = 8'(DEADTIME - 1);
    localparam logic [7:0] GAP_LOAD = 8'(VALVE_GAP - 1);
    m_state_t m_state, m_nxt;
    v_state_t v_state, v_nxt;
    logic [7:0] m_cnt, m_cnt_nxt, v_cnt, v_cnt_nxt;
    logic ok, fwd_ok, rev_ok, fill_ok, rel_ok;
    logic [2:0] f_set;
    assign ok      = bus.ena & ~bus.estop;
    assign fwd_ok  = bus.req_forward & ~bus.req_reverse & bus.door_closed & ok;
    assign rev_ok  = bus.req_reverse & ~bus.req_forward & bus.door_closed & ok;
    assign fill_ok = bus.req_fill & ~bus.req_release & bus.door_closed & ok;
    assign rel_ok  = bus.req_release & ok;
    assign f_set   = {~bus.door_closed & (m_state == M_FWD || m_state == M_REV),
                      bus.req_forward & bus.req_reverse, bus.estop};
    always_comb begin
        m_nxt     = m_state;
        m_cnt_nxt = m_cnt;
        v_nxt     = v_state;
        v_cnt_nxt = v_cnt;
        // estop restarts the full dead time even from mid-brake
        if (bus.estop) begin
            m_nxt     = M_BRAKE;
            m_cnt_nxt = DT_LOAD;
        end else begin
            case (m_state)
                M_IDLE:  m_nxt = fwd_ok ? M_FWD : rev_ok ? M_REV : M_IDLE;
                M_FWD:   if (!fwd_ok) begin m_nxt = M_BRAKE; m_cnt_nxt = DT_LOAD; end
                M_REV:   if (!rev_ok) begin m_nxt = M_BRAKE; m_cnt_nxt = DT_LOAD; end
                M_BRAKE: begin
                    m_nxt     = (m_cnt == 8'd0) ? M_IDLE : M_BRAKE;
                    m_cnt_nxt = (m_cnt == 8'd0) ? 8'd0 : m_cnt - 8'd1;
                end
            endcase
        end
        if (bus.estop) begin
            v_nxt     = V_CLOSED;
            v_cnt_nxt = 8'd0;
        end else begin
            case (v_state)
                V_CLOSED:  v_nxt = rel_ok ? V_RELEASE : fill_ok ? V_FILL : V_CLOSED;
                V_FILL:    if (!fill_ok) begin v_nxt = V_GAP; v_cnt_nxt = GAP_LOAD; end
                V_RELEASE: if (!rel_ok) begin v_nxt = V_GAP; v_cnt_nxt = GAP_LOAD; end
                V_GAP: begin
                    v_nxt     = (v_cnt == 8'd0) ? V_CLOSED : V_GAP;
                    v_cnt_nxt = (v_cnt == 8'd0) ? 8'd0 : v_cnt - 8'd1;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            m_state         <= M_IDLE;
            v_state         <= V_CLOSED;
            m_cnt           <= 8'd0;
            v_cnt           <= 8'd0;
            bus.out_forward <= 1'b0;
            bus.out_reverse <= 1'b0;
            bus.out_fill    <= 1'b0;
            bus.out_release <= 1'b0;
            bus.busy        <= 1'b0;
            bus.fault       <= 3'b000;
        end else begin
            m_state         <= m_nxt;
            v_state         <= v_nxt;
            m_cnt           <= m_cnt_nxt;
            v_cnt           <= v_cnt_nxt;
            bus.out_forward <= m_nxt == M_FWD;
            bus.out_reverse <= m_nxt == M_REV;
            bus.out_fill    <= v_nxt == V_FILL;
            bus.out_release <= v_nxt == V_RELEASE;
            bus.busy        <= (m_nxt == M_BRAKE) || (v_nxt == V_GAP);
            bus.fault       <= (bus.clear_fault ? 3'b000 : bus.fault) | f_set;
        end
    end
endmodule

// File: doc/actuator_guard.md
ACTUATOR_GUARD -- requirements
Module: actuator_guard

Interface
REQ-001 The block SHALL have parameter DEADTIME, default 8: motor-off cycles required between any motor run and the next run (range 2..255).
REQ-002 The block SHALL have parameter VALVE_GAP, default 2: all-valves-closed cycles required between fill and release (range 1..255).
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous reset, active-high.
REQ-005 The block SHALL have port ena  input  1  run enable; low forces motor to stop via brake and valves to close.
REQ-006 The block SHALL have ports req_fill, req_release, req_forward, req_reverse  input  1 each  actuator requests from the processor ctrl_* outputs.
REQ-007 The block SHALL have port door_closed  input  1  door interlock; high = closed.
REQ-008 The block SHALL have port estop  input  1  emergency stop, level-sensitive.
REQ-009 The block SHALL have port clear_fault  input  1  single-cycle pulse that clears fault bits.
REQ-010 The block SHALL have ports out_fill, out_release, out_forward, out_reverse  output  1 each  registered actuator drives.
REQ-011 The block SHALL have port busy  output  1  high while in a motor brake interval or a valve gap interval.
REQ-012 The block SHALL have port fault  output  3  sticky flags: [0] estop seen, [1] forward+reverse requested together, [2] door opened while motor running.

Function
REQ-013 Motor FSM states SHALL be M_IDLE, M_FWD, M_REV, M_BRAKE; out_forward=1 only in M_FWD; out_reverse=1 only in M_REV.
REQ-014 M_IDLE->M_FWD SHALL occur when req_forward & !req_reverse & door_closed & ena & !estop; M_IDLE->M_REV is symmetric; output asserts on the edge that requests are sampled (1-cycle latency).
REQ-015 M_FWD SHALL go to M_BRAKE when req_forward drops, req_reverse rises, door_closed drops, ena drops or estop rises; M_REV is symmetric.
REQ-016 Entry to M_BRAKE SHALL load an 8-bit counter with DEADTIME-1; the counter decrements each cycle; M_BRAKE->M_IDLE when the counter is 0; both motor outputs are low for exactly DEADTIME cycles.
REQ-017 Direction reversal SHALL therefore yield FWD, DEADTIME off cycles, 1 IDLE cycle, then REV; never both outputs high, never adjacent-cycle direction change.
REQ-018 req_forward & req_reverse together SHALL set fault[1] and be treated as no motor request.
REQ-019 Valve FSM states SHALL be V_CLOSED, V_FILL, V_RELEASE, V_GAP; at most one valve output high.
REQ-020 V_CLOSED->V_FILL SHALL require req_fill & !req_release & door_closed & ena & !estop; V_CLOSED->V_RELEASE SHALL require req_release & ena & !estop (door state ignored).
REQ-021 When req_fill & req_release are both high, release SHALL win (no fault); the system drains rather than fills.
REQ-022 Leaving V_FILL or V_RELEASE for any reason SHALL enter V_GAP, loading VALVE_GAP-1; V_GAP->V_CLOSED at count 0.
REQ-023 Door opening in V_FILL SHALL end fill (->V_GAP); door opening SHALL NOT affect V_RELEASE.
REQ-024 fault[2] SHALL set when door_closed is low while the motor FSM is M_FWD or M_REV.
REQ-025 estop high SHALL on the next edge drive all outputs low, force motor to M_BRAKE with full DEADTIME reload (from any state, including mid-brake), force valves to V_CLOSED, and set fault[0]; no new run while estop is high.
REQ-026 Fault bits SHALL be sticky; clear_fault clears all bits, except a bit whose set condition is true in the same cycle stays set (set wins).
REQ-027 busy SHALL equal (motor state == M_BRAKE) | (valve state == V_GAP), registered with state.
REQ-028 Requests arriving during M_BRAKE or V_GAP SHALL be ignored until IDLE/CLOSED, then evaluated normally.

Reset
REQ-029 rst SHALL put the motor in M_IDLE, the valves in V_CLOSED, counters at 0, all out_* low, busy low, and fault 3'b000; rst overrides all inputs.
REQ-030 rst asserted mid-brake or mid-gap SHALL abort the interval immediately (no residual dead time after reset).

Verification
REQ-031 The bench SHALL cover: req_forward held, door closed -> out_forward high 1 cycle later; then req_reverse only -> forward low, 8 cycles all-off with busy=1, 1 idle cycle, out_reverse high.
REQ-032 The bench SHALL cover: req_fill then req_release (fill dropped) -> out_fill low, 2 cycles closed with busy=1, then out_release high; req_fill&req_release from V_CLOSED -> out_release only.
REQ-033 The bench SHALL cover: estop pulse during M_FWD with out_fill high -> all outputs 0 next cycle, fault=3'b001, motor idle only after 8 cycles, and no restart while estop high.
REQ-034 The bench SHALL cover: req_forward&req_reverse together -> no motor output, fault[1]=1; clear_fault with requests still conflicting -> fault[1] stays 1; conflict removed then clear_fault -> 0.
REQ-035 The bench SHALL cover: door opens during M_REV and V_RELEASE -> reverse stops into brake, fault[2]=1, release stays on; rst mid-brake -> busy=0 and all outputs 0 on the next cycle.
